rr_arbiter: RTL and testbench
=============================

# rr_arbiter

Five-way round-robin arbiter with a bounded grant-hold counter, producing the registered one-hot grant vector that the arbiter property checker consumes. Samples `req` every cycle and presents `gnt` one cycle later, so every grant bit is justified by the request bit of the previous cycle. Sits between the requesting masters and the shared resource's mux select.

## Interface
- `N`, 5: number of requesters; supported range is 2..8.
- `MAX_HOLD`, 4: maximum consecutive cycles one owner may keep the grant while it keeps requesting; must be at least 1.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req` in N: request vector; bit i means requester i wants the resource.
- `lock` in 1: present only with `ARB_LOCK_EN`; the current owner asks to extend its grant.
- `gnt` out N: registered grant; zero-hot or one-hot.
- `gnt_vld` out 1: registered; equals OR of `gnt`.
- `gnt_id` out $clog2(N): registered binary index of the granted requester; 0 when `gnt_vld`=0.

## Operation
- State registers:
  - `gnt`.
  - `ptr`: last owner index.
  - `hold_cnt`: width $clog2(MAX_HOLD+1), saturating at MAX_HOLD-1.
- States:
  - IDLE: `gnt`=0.
  - OWN(o): `gnt`[o]=1.
- Each cycle, `gnt` for the next cycle is decided from the sampled `req` only. Rules, in priority order:
  1. **Keep.** In OWN(o), `req[o]`=1 and `hold_cnt` < MAX_HOLD-1: stay in OWN(o) and increment `hold_cnt`.
  2. **Rotate.** Otherwise, search `req` circularly from `ptr`+1 mod N through `ptr`.
     - On the first set bit j: go to OWN(j), set `ptr`=j, clear `hold_cnt`.
     - The current owner is checked last. If it is the sole requester when its hold expires, it is re-granted and `hold_cnt` restarts at 0.
  3. **Release.** No `req` bit set: go to IDLE. `ptr` and `hold_cnt` hold their values.
- In IDLE with requests present, the search starts after `ptr`, the last owner before going idle.
- MAX_HOLD=1 forces a rotation decision every cycle: strict round-robin.
- Invariants, all checked by the bench:
  - `gnt` is always zero-hot or one-hot.
  - `gnt[i]` at cycle t implies `req[i]` at cycle t-1.
  - Any requester held continuously is granted within (N-1)·MAX_HOLD+1 cycles.

## Timing
- Latency: `req` sampled at edge k drives `gnt`, `gnt_vld` and `gnt_id` after edge k. One-cycle latency; no combinational path from `req` to outputs.
- Dropping `req[o]` at cycle t removes `gnt[o]` at cycle t+1.
  - The same edge may grant another requester.
  - No dead cycle is inserted.
- Reset asserted:
  - Immediately, with no clock needed: `gnt`=0, `gnt_vld`=0, `gnt_id`=0.
  - Internal state: `ptr`=N-1, so requester 0 is searched first, and `hold_cnt`=0.
- Reset mid-grant drops the grant asynchronously. After release, the first edge with `req`≠0 grants the lowest-index requester.
- Reset deassertion is synchronised externally. The first active edge after deassertion evaluates normally.

## Configuration
- `ARB_LOCK_EN` defined:
  - The `lock` port exists.
  - In OWN(o), `req[o]`=1 and `lock`=1 keep the grant regardless of `hold_cnt`; `hold_cnt` saturates at MAX_HOLD-1.
  - `lock` without `req[o]` has no effect.
  - `lock` in IDLE has no effect.
- `ARB_LOCK_EN` undefined: the `lock` port is absent and the Keep rule uses `hold_cnt` only.

## Test plan
- Reset release, `req`=5'b10100 → after one edge `gnt`=5'b00100, `gnt_id`=2, `gnt_vld`=1.
- `req`=5'b11111 held with MAX_HOLD=4, starting from reset → grant sequence is requester 0 for 4 cycles, then 1, 2, 3, 4 for 4 cycles each, then back to 0.
- Only `req[3]` held for 10 cycles → `gnt`=5'b01000 every cycle; `hold_cnt` cycles 0..3 with a re-grant each time it wraps.
- Owner 1 with `hold_cnt`=1 drops `req[1]` while `req`=5'b00001 → the next edge gives `gnt`=5'b00001, `ptr`=0; the edge after `req`=0 gives `gnt`=0.
- Reset pulsed low mid-cycle while `gnt`=5'b10000 → `gnt`=0 immediately, without waiting for an edge; after release with `req`=5'b10001, `gnt`=5'b00001.
- With `ARB_LOCK_EN`, owner 2 holds `req[2]`=1 and `lock`=1 for 12 cycles while `req`=5'b11111 → `gnt`=5'b00100 for all 12 cycles. The edge after `lock` drops gives `gnt`=5'b01000.

Source files
------------

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// N-way round-robin arbiter with a bounded grant-hold counter. The request
// vector is sampled on every rising edge and the grant is presented one cycle
// later from registers only, so each grant bit is backed by the request bit
// of the previous cycle. There is no combinational path from req to outputs.
//
// Decision order each cycle:
//   keep    - the current owner still requests and has hold budget left
//   rotate  - search req circularly starting after the last owner; the last
//             owner is visited last, so a sole requester is simply re-granted
//   release - nothing requested: go idle, pointer and hold count are kept
//
// Optional feature macro: ARB_LOCK_EN
//   When defined, the lock_i port exists and lets the current owner keep the
//   grant past its hold budget while it keeps requesting.
//
// Parameters:
//   N         number of requesters (2..8)
//   MAX_HOLD  max consecutive cycles one owner keeps the grant (>= 1)
//
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset
//   req_i      request vector, bit i = requester i wants the resource
//   lock_i     (ARB_LOCK_EN only) owner asks to extend its grant
//   gnt_o      registered grant, zero-hot or one-hot
//   gnt_vld_o  registered, OR of gnt_o
//   gnt_id_o   registered binary index of the owner, 0 when idle
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N        = 5,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N-1:0]         req_i,
`ifdef ARB_LOCK_EN
    input  logic                 lock_i,
`endif
    output logic [N-1:0]         gnt_o,
    output logic                 gnt_vld_o,
    output logic [$clog2(N)-1:0] gnt_id_o
);

    localparam int IDW = $clog2(N);
    localparam int HCW = $clog2(MAX_HOLD + 1);

    // Hold counter saturates here; reaching it means the budget is used up.
    localparam logic [HCW-1:0] HOLD_SAT = HCW'(MAX_HOLD - 1);
    // Pointer reset value makes requester 0 the first one searched.
    localparam logic [IDW-1:0] PTR_RST  = IDW'(N - 1);

    logic [N-1:0]   gnt_q,     gnt_d;
    logic           gnt_vld_q, gnt_vld_d;
    logic [IDW-1:0] gnt_id_q,  gnt_id_d;
    logic [IDW-1:0] ptr_q,     ptr_d;
    logic [HCW-1:0] hold_q,    hold_d;

    logic           owner_req;
    logic           hold_room;
    logic           keep;
    logic           found;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx;

    // While a grant is active, ptr_q is the owner index.
    assign owner_req = gnt_vld_q && req_i[ptr_q];
    assign hold_room = (hold_q < HOLD_SAT);

`ifdef ARB_LOCK_EN
    assign keep = owner_req && (hold_room || lock_i);
`else
    assign keep = owner_req && hold_room;
`endif

    // Circular search from ptr+1 through ptr; the last owner is checked last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDW'((int'(ptr_q) + k) % N);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_vld_d = 1'b0;
        gnt_id_d  = '0;
        if (keep) begin
            gnt_vld_d = 1'b1;
            gnt_id_d  = ptr_q;
            // With lock the owner may stay beyond the budget; count saturates.
            if (hold_room) begin
                hold_d = hold_q + HCW'(1);
            end
        end else if (found) begin
            gnt_vld_d = 1'b1;
            gnt_id_d  = pick;
            ptr_d     = pick;
            hold_d    = '0;
        end
        // Otherwise release: idle, ptr and hold count retain their values.
    end

    // One-hot decode of the next owner index.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_gnt_dec
            assign gnt_d[gi] = gnt_vld_d && (gnt_id_d == IDW'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_id_q  <= '0;
            ptr_q     <= PTR_RST;
            hold_q    <= '0;
        end else begin
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_vld_o = gnt_vld_q;
    assign gnt_id_o  = gnt_id_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter
//
// Table-driven directed vectors, hand-written multi-cycle sequences (full
// rotation, asynchronous reset mid-grant, lock extension when ARB_LOCK_EN is
// defined) and a randomized phase checked against a behavioural model that
// tracks owner / last owner / number of consecutive cycles granted.
// Invariants (one-hot, grant justified by previous request, bounded wait)
// are checked on every cycle.
// ---------------------------------------------------------------------------
module tb_rr_arbiter;

    localparam int N        = 5;
    localparam int MAX_HOLD = 4;
    localparam int IDW      = $clog2(N);
    localparam int WAIT_MAX = (N - 1) * MAX_HOLD;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic           lock_v;
    logic [N-1:0]   gnt;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_id;

    always #5 clk = ~clk;

    rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
`ifdef ARB_LOCK_EN
        .lock_i    (lock_v),
`endif
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld),
        .gnt_id_o  (gnt_id)
    );

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int m_owner;   // -1 when idle
    int m_ptr;     // last owner
    int m_streak;  // consecutive cycles the owner has held the grant
    int wait_c [N];
    bit starve_en;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] gnt;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_ptr    = N - 1;
        m_streak = 0;
        for (int i = 0; i < N; i++) wait_c[i] = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic lk);
        bit keep;
        keep = 1'b0;
        if (m_owner >= 0 && r[m_owner])
            keep = (m_streak < MAX_HOLD) || lk;
        if (keep) begin
            if (m_streak < MAX_HOLD) m_streak++;
        end else if (r == '0) begin
            m_owner = -1;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (r[j]) begin
                    m_owner  = j;
                    m_ptr    = j;
                    m_streak = 1;
                    break;
                end
            end
        end
    endtask

    // One clock: drive inputs, advance model, check after the edge.
    // exp_tbl < 0 means no independent expected value for this cycle.
    task automatic cycle(input logic [N-1:0] r, input logic lk, input int exp_tbl,
                         input string tag, input bit verbose);
        logic [N-1:0] m_gnt;
        int maxw;
        req    = r;
        lock_v = lk;
        model_step(r, lk);
        @(posedge clk);
        #1;
        m_gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        chk({tag, ".gnt"}, 32'(gnt), 32'(m_gnt));
        chk({tag, ".vld"}, 32'(gnt_vld), 32'(m_owner >= 0));
        chk({tag, ".id"},  32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        if (exp_tbl >= 0) chk({tag, ".exp"}, 32'(gnt), 32'(exp_tbl));
        chk({tag, ".onehot0"}, 32'($onehot0(gnt)), 32'd1);
        chk({tag, ".justified"}, 32'(gnt & ~r), 32'd0);
        maxw = 0;
        for (int i = 0; i < N; i++) begin
            if (r[i] && !gnt[i]) wait_c[i]++;
            else wait_c[i] = 0;
            if (wait_c[i] > maxw) maxw = wait_c[i];
        end
        if (starve_en) chk({tag, ".wait_bound"}, 32'(maxw <= WAIT_MAX), 32'd1);
        if (verbose)
            $display("%s req=%b lock=%b gnt=%b vld=%b id=%0d", tag, r, lk, gnt, gnt_vld, gnt_id);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        req    = '0;
        lock_v = 1'b0;
        #1;
        chk("rst.gnt", 32'(gnt), 32'd0);
        chk("rst.vld", 32'(gnt_vld), 32'd0);
        chk("rst.id",  32'(gnt_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [N-1:0] r;
        rst_n     = 1'b0;
        req       = '0;
        lock_v    = 1'b0;
        starve_en = 1'b1;
        model_reset();

        tbl[0]  = '{5'b10100, 5'b00100};
        tbl[1]  = '{5'b10100, 5'b00100};
        tbl[2]  = '{5'b00000, 5'b00000};
        tbl[3]  = '{5'b00011, 5'b00001};
        tbl[4]  = '{5'b00010, 5'b00010};
        tbl[5]  = '{5'b00011, 5'b00010};
        tbl[6]  = '{5'b00001, 5'b00001};
        tbl[7]  = '{5'b00000, 5'b00000};
        tbl[8]  = '{5'b01000, 5'b01000};
        tbl[9]  = '{5'b01000, 5'b01000};
        tbl[10] = '{5'b01000, 5'b01000};
        tbl[11] = '{5'b01000, 5'b01000};
        tbl[12] = '{5'b01000, 5'b01000};
        tbl[13] = '{5'b10001, 5'b10000};

        // Reset state with no clock edge seen yet
        #3;
        chk("por.gnt", 32'(gnt), 32'd0);
        chk("por.vld", 32'(gnt_vld), 32'd0);
        chk("por.id",  32'(gnt_id), 32'd0);

        do_reset();
        for (int v = 0; v < 14; v++)
            cycle(tbl[v].req, 1'b0, int'(tbl[v].gnt), $sformatf("tbl%0d", v), 1'b1);

        // Asynchronous reset while gnt=10000: must drop without an edge
        #3;
        rst_n = 1'b0;
        #1;
        chk("async.gnt", 32'(gnt), 32'd0);
        chk("async.vld", 32'(gnt_vld), 32'd0);
        chk("async.id",  32'(gnt_id), 32'd0);
        $display("async reset gnt=%b vld=%b id=%0d", gnt, gnt_vld, gnt_id);
        #2;
        rst_n = 1'b1;
        model_reset();
        cycle(5'b10001, 1'b0, 5'b00001, "post_rst", 1'b1);

        // Full rotation from reset with all requesting
        do_reset();
        for (int k = 0; k < 24; k++)
            cycle(5'b11111, 1'b0, int'(1 << ((k / MAX_HOLD) % N)), $sformatf("rot%0d", k), 1'b1);

`ifdef ARB_LOCK_EN
        do_reset();
        cycle(5'b00100, 1'b0, 5'b00100, "lock_start", 1'b1);
        for (int k = 0; k < 12; k++)
            cycle(5'b11111, 1'b1, 5'b00100, $sformatf("lock%0d", k), 1'b1);
        cycle(5'b11111, 1'b0, 5'b01000, "lock_drop", 1'b1);
`endif

        // Randomized phase: requests mostly persist, bits toggle occasionally
        do_reset();
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 4) == 0) r[i] = ~r[i];
            if ($urandom_range(0, 63) == 0) r = '1;
            cycle(r, 1'b0, -1, $sformatf("rnd%0d", c), 1'b0);
        end

`ifdef ARB_LOCK_EN
        // Lock can legitimately extend waits, so the wait bound is not checked here.
        do_reset();
        starve_en = 1'b0;
        r = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 4) == 0) r[i] = ~r[i];
            cycle(r, 1'($urandom_range(0, 2) == 0), -1, $sformatf("rndl%0d", c), 1'b0);
        end
        starve_en = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
